// File: rtl/fifo_defines_pkg.sv
// Shared FIFO/link definitions: SPI word receiver state encoding and default sizing.
`ifndef INT_BITS
`define INT_BITS 16
`endif

package fifo_defines_pkg;

   localparam int unsigned SPI_RX_DATA_W  = `INT_BITS;
   localparam int unsigned SPI_RX_DEPTH   = 8;
   localparam int unsigned SPI_RX_TIMEOUT = 64;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      PUSH  = 2'd2
   } spi_rx_state_t;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer with a history flop and a registered rising-edge pulse.
module sync_edge_det (
   input  logic clk,
   input  logic rst,
   input  logic i_async,
   output logic o_sync,
   output logic o_rise
);

   logic r_meta;
   logic r_sync;
   logic r_hist;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
         r_hist <= 1'b0;
         o_rise <= 1'b0;
      end else begin
         r_meta <= i_async;
         r_sync <= r_meta;
         r_hist <= r_sync;
         o_rise <= r_sync & ~r_hist;
      end
   end

   assign o_sync = r_sync;

endmodule

// File: rtl/spi_word_receiver.sv
// Oversampling SPI receive path: reassembles MSB-first words and queues them
// in a show-ahead FIFO with sticky overflow and framing-error flags.
module spi_word_receiver
   import fifo_defines_pkg::*;
#(
   parameter int unsigned DATA_W  = SPI_RX_DATA_W,
   parameter int unsigned DEPTH   = SPI_RX_DEPTH,
   parameter int unsigned TIMEOUT = SPI_RX_TIMEOUT
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     sclk_i,
   input  logic                     mosi_i,
   input  logic                     done_i,
   output logic [DATA_W-1:0]        data_o,
   output logic                     valid_o,
   input  logic                     ready_i,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     overflow_o,
   output logic                     frame_err_o,
   input  logic                     clr_i
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;
   localparam int unsigned BW = $clog2(DATA_W + 1);
   localparam int unsigned TW = $clog2(TIMEOUT + 1);

   logic w_sclk_re, w_done_re, w_mosi;
   logic w_unused_sclk_sync, w_unused_done_sync, w_unused_mosi_re;

   sync_edge_det u_sync_sclk (.clk(clk), .rst(rst), .i_async(sclk_i),
                              .o_sync(w_unused_sclk_sync), .o_rise(w_sclk_re));
   sync_edge_det u_sync_mosi (.clk(clk), .rst(rst), .i_async(mosi_i),
                              .o_sync(w_mosi), .o_rise(w_unused_mosi_re));
   sync_edge_det u_sync_done (.clk(clk), .rst(rst), .i_async(done_i),
                              .o_sync(w_unused_done_sync), .o_rise(w_done_re));

   spi_rx_state_t     r_state;
   logic [DATA_W-1:0] r_sr;
   logic [DATA_W-1:0] r_wr_data;
   logic [BW-1:0]     r_bit_cnt;
   logic [TW-1:0]     r_to_cnt;
   logic              r_wr_en;
   logic              r_err;
   logic [DATA_W-1:0] w_sr_shift;

   assign w_sr_shift = DATA_W'({r_sr, w_mosi});

   // Word assembly; r_wr_en/r_err are one-cycle requests to the FIFO and flag logic.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= IDLE;
         r_sr      <= '0;
         r_wr_data <= '0;
         r_bit_cnt <= '0;
         r_to_cnt  <= '0;
         r_wr_en   <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         r_wr_en <= 1'b0;
         r_err   <= 1'b0;
         case (r_state)
            IDLE: begin
               r_bit_cnt <= '0;
               r_to_cnt  <= '0;
               if (w_sclk_re) begin
                  r_sr      <= DATA_W'(w_mosi);
                  r_bit_cnt <= BW'(1);
                  r_state   <= (DATA_W == 1) ? PUSH : SHIFT;
               end
            end
            SHIFT: begin
               if (w_sclk_re) begin
                  r_sr      <= w_sr_shift;
                  r_bit_cnt <= r_bit_cnt + BW'(1);
                  r_to_cnt  <= '0;
                  if (r_bit_cnt == BW'(DATA_W - 1)) r_state <= PUSH;
               end else if (w_done_re || (r_to_cnt == TW'(TIMEOUT - 1))) begin
                  r_err     <= 1'b1;
                  r_sr      <= '0;
                  r_bit_cnt <= '0;
                  r_to_cnt  <= '0;
                  r_state   <= IDLE;
               end else begin
                  r_to_cnt <= r_to_cnt + TW'(1);
               end
            end
            PUSH: begin
               r_wr_en   <= 1'b1;
               r_wr_data <= r_sr;
               r_err     <= w_sclk_re;
               r_bit_cnt <= '0;
               r_to_cnt  <= '0;
               r_state   <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [PW-1:0]     r_wr_ptr, r_rd_ptr;
   logic [PW-1:0]     w_wr_ptr_nxt, w_rd_ptr_nxt, w_count_nxt;
   logic              w_full, w_pop, w_push_ok;
   logic [DATA_W-1:0] w_head_nxt;

   assign w_full       = (count_o == PW'(DEPTH));
   assign w_pop        = valid_o & ready_i;
   assign w_push_ok    = r_wr_en & (~w_full | w_pop);
   assign w_wr_ptr_nxt = r_wr_ptr + PW'(w_push_ok);
   assign w_rd_ptr_nxt = r_rd_ptr + PW'(w_pop);
   assign w_count_nxt  = w_wr_ptr_nxt - w_rd_ptr_nxt;
   // A word written into an otherwise-empty queue bypasses storage to the head.
   assign w_head_nxt   = (w_push_ok && (w_count_nxt == PW'(1))) ? r_wr_data
                                                                : r_mem[w_rd_ptr_nxt[AW-1:0]];

   always_ff @(posedge clk) begin
      if (w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= r_wr_data;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         count_o     <= '0;
         valid_o     <= 1'b0;
         data_o      <= '0;
         overflow_o  <= 1'b0;
         frame_err_o <= 1'b0;
      end else begin
         r_wr_ptr    <= w_wr_ptr_nxt;
         r_rd_ptr    <= w_rd_ptr_nxt;
         count_o     <= w_count_nxt;
         valid_o     <= (w_count_nxt != '0);
         if (w_pop || (w_push_ok && (count_o == '0))) data_o <= w_head_nxt;
         overflow_o  <= (r_wr_en & w_full & ~w_pop) | (overflow_o & ~clr_i);
         frame_err_o <= r_err | (frame_err_o & ~clr_i);
      end
   end

endmodule

// File: doc/spi_word_receiver.md
# spi_word_receiver

Receive side of the waveform link: samples the serial `sclk`/`mosi`/`done` stream produced by the top-level SPI transmitter, reassembles MSB-first words of `DATA_W` bits, and buffers them in a small internal FIFO with a valid/ready read port. It sits on the consumer end of the link, either in the checker board model or in a downstream DAC/loopback path. All logic runs in the single `clk` domain with oversampled, synchronized serial inputs.

## Interface
- `DATA_W`, 16, bits per serial word (MSB first)
- `DEPTH`, 8, FIFO depth in words (power of two, ≥2)
- `TIMEOUT`, 64, max `clk` cycles between `sclk` rising edges inside a word before abort
- `clk`  in  1  system clock; the only clock
- `rst`  in  1  asynchronous, active-low reset
- `sclk_i`  in  1  serial clock from transmitter (async to `clk`)
- `mosi_i`  in  1  serial data, valid on `sclk_i` rising edge
- `done_i`  in  1  transmitter end-of-word strobe (async, level ≥3 `clk` high)
- `data_o`  out  DATA_W  head-of-FIFO word (show-ahead)
- `valid_o`  out  1  FIFO non-empty
- `ready_i`  in  1  consumer accepts `data_o` when `valid_o && ready_i`
- `count_o`  out  $clog2(DEPTH)+1  words held
- `overflow_o`  out  1  sticky: word dropped on full FIFO
- `frame_err_o`  out  1  sticky: partial word aborted
- `clr_i`  in  1  synchronous clear of both sticky flags

## Operation
- `sclk_i`, `mosi_i`, `done_i` each pass a 2-flop synchronizer plus one history flop; rise pulses `sclk_re`, `done_re` = sync & ~history.
- FSM states: IDLE, SHIFT, PUSH.
  - IDLE: `bit_cnt`=0. On `sclk_re`: shift in `mosi`, `bit_cnt`=1, go to SHIFT (or PUSH if `DATA_W`==1). `done_re` ignored.
  - SHIFT: on `sclk_re`: shift register `{sr[DATA_W-2:0], mosi}`, `bit_cnt`++; when the `DATA_W`-th bit is shifted, go to PUSH. On `done_re` before word complete: set `frame_err_o`, discard, go to IDLE. Timeout counter reloads on every `sclk_re`; reaching `TIMEOUT`: set `frame_err_o`, discard, go to IDLE.
  - PUSH: one cycle; write `sr` to FIFO; go to IDLE. An `sclk_re` in PUSH is a protocol violation: it is dropped and `frame_err_o` set.
- `done_re` arriving in IDLE right after a completed word is the normal case and causes no error.
- FIFO: circular buffer, `wr_ptr`/`rd_ptr` with wrap bit, `count_o` = ptr difference.
  - Pop: `valid_o && ready_i`; `rd_ptr` advances, wraps at `DEPTH`.
  - Push when full with no pop: word dropped, `overflow_o` set, contents unchanged.
  - Push when full with simultaneous pop: both accepted, `count_o` unchanged.
  - Push and pop on a non-full, non-empty FIFO: both accepted, `count_o` unchanged.
  - Push when empty: no same-cycle pop, because `valid_o` is low.
- Sticky flags: `clr_i` clears; set and clear in the same cycle means set wins.
- Reset (async, any state, including mid-word): FSM→IDLE, shift register, `bit_cnt`, and timeout counter cleared, FIFO emptied, synchronizers cleared to 0. Outputs: `data_o`=0, `valid_o`=0, `count_o`=0, `overflow_o`=0, `frame_err_o`=0.

## Timing
- Input constraint: `sclk_i` high and low each ≥3 `clk` periods; `mosi_i` stable ≥3 `clk` before and after the `sclk_i` rise.
- `sclk_re` is asserted in the 3rd `clk` cycle after the first clock edge that samples `sclk_i` high. The shift occurs at the end of that cycle.
- Last-bit shift to FIFO write: 1 cycle (PUSH). Write to `valid_o`/`count_o` update: registered, visible the following cycle.
- Total latency, empty FIFO: `valid_o` rises 2 `clk` after the last-bit shift edge.
- `data_o` is valid whenever `valid_o`=1. It changes only on a pop or on an empty→non-empty write.
- Throughput: one word per `DATA_W` `sclk` periods; the FIFO absorbs bursts while `ready_i`=0.

## Structure
- Add to `fifo_defines_pkg`: `spi_rx_state_t` enum (IDLE, SHIFT, PUSH) and default constants `SPI_RX_DATA_W`, `SPI_RX_DEPTH`, `SPI_RX_TIMEOUT`. Where the link word equals the sample width, `DATA_W` defaults from `` `INT_BITS ``.
- One sub-module: `sync_edge_det` (2-flop sync + rise pulse), instantiated three times. The FIFO storage stays inline.

## Test plan
- `DATA_W`=16: send 0xA5C3 MSB first, `sclk` 8 `clk` high / 8 low, then `done` -> `data_o`=0xA5C3, `valid_o`=1, `count_o`=1, no flags set.
- `ready_i`=0: send 9 words 0x0001..0x0009 with `DEPTH`=8 -> `count_o`=8, `overflow_o`=1. Then `ready_i`=1 -> reads 0x0001..0x0008 in order; 0x0009 is lost.
- Send 5 bits then assert `done` -> `frame_err_o`=1, `count_o`=0. Next full word 0x1234 is received correctly.
- Send 10 bits then idle 100 cycles with `TIMEOUT`=64 -> `frame_err_o`=1, FSM back in IDLE. `clr_i` pulse -> flag returns to 0.
- FIFO full, `ready_i`=1 in the same cycle a new word pushes -> `count_o` stays 8, no overflow, order preserved.
- Assert `rst` low after 7 bits -> all outputs 0. After release, word 0xFFFF is received intact.
